// File: rtl/multiciclo_control_pkg.sv
// Shared encodings for the multicycle RV32I control unit and its datapath:
// state codes, opcodes, mux-select encodings and the control word layout.
package multiciclo_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_LUI      = 4'd12
  } state_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_BRANCH = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REG   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JALR   = 2'd2;

  // Full set of datapath controls produced by the FSM each cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       read_memory;
    logic       write_memory;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       retire;
  } ctrl_t;

  // States that hold for MEM_WAIT+1 cycles while the memory responds.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
  endfunction

endpackage

// File: rtl/multiciclo_control_opdecode.sv
// Opcode decode used in DECODE: selects the first execution state of the
// instruction and flags opcodes this core does not implement.
module multiciclo_control_opdecode
  import multiciclo_control_pkg::*;
(
  input  logic [6:0] opcode,
  output state_t     next_state,
  output logic       illegal
);

  // Pure lookup from opcode to the next state; unknown opcodes refetch.
  always_comb begin
    next_state = ST_FETCH;
    illegal    = 1'b0;
    case (opcode)
      OPC_RTYPE:           next_state = ST_EXEC_R;
      OPC_ITYPE:           next_state = ST_EXEC_I;
      OPC_LOAD, OPC_STORE: next_state = ST_MEMADR;
      OPC_BRANCH:          next_state = ST_BRANCH;
      OPC_JAL:             next_state = ST_JAL;
      OPC_JALR:            next_state = ST_JALR;
      OPC_LUI:             next_state = ST_LUI;
      OPC_AUIPC:           next_state = ST_ALUWB;  // ALUOut already holds oldPC+imm
      default: begin
        next_state = ST_FETCH;
        illegal    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multiciclo_control.sv
// Moore control FSM for the multicycle RV32I datapath. Memory states stretch
// to MEM_WAIT+1 cycles via a wait counter (MEM_WAIT must be < 2**WAIT_W).
// All control outputs are forced to 0 while reset is high, which also aborts
// any memory access in progress.
module multiciclo_control
  import multiciclo_control_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int WAIT_W   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] iOpcode,
  output logic       oPCWrite,
  output logic       oPCWriteCond,
  output logic       oIorD,
  output logic       oReadMemory,
  output logic       oWriteMemory,
  output logic       oIRWrite,
  output logic       oRegWrite,
  output logic [1:0] oMemtoReg,
  output logic [1:0] oALUSrcA,
  output logic [1:0] oALUSrcB,
  output logic [1:0] oALUOp,
  output logic [1:0] oPCSource,
  output logic       oIllegal,
  output logic       oRetire,
  output logic [3:0] oState
);

  state_t            state, next_state;
  state_t            dec_state;
  logic              dec_illegal;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              last_wait;
  ctrl_t             ctrl;

  multiciclo_control_opdecode u_opdecode (
    .opcode     (iOpcode),
    .next_state (dec_state),
    .illegal    (dec_illegal)
  );

  assign last_wait = (wait_cnt == WAIT_W'(MEM_WAIT));

  // State and wait counter registers; reset parks the FSM in FETCH.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Counter runs only while a memory state is waiting; leaving a memory state
  // always happens on its last cycle, so the count is 0 on every entry.
  always_comb begin
    wait_cnt_next = '0;
    if (is_mem_state(state) && !last_wait)
      wait_cnt_next = wait_cnt + 1'b1;
  end

  // Next-state and Moore control decode.
  always_comb begin
    ctrl       = '0;
    next_state = ST_FETCH;
    case (state)
      ST_FETCH: begin
        ctrl.read_memory = 1'b1;
        ctrl.alu_src_a   = SRCA_PC;
        ctrl.alu_src_b   = SRCB_FOUR;
        ctrl.alu_op      = ALUOP_ADD;
        ctrl.pc_source   = PCS_ALU;
        if (last_wait) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          next_state    = ST_DECODE;
        end else begin
          next_state    = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.illegal   = dec_illegal;
        next_state     = dec_state;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        next_state     = (iOpcode == OPC_STORE) ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        ctrl.i_or_d      = 1'b1;
        ctrl.read_memory = 1'b1;
        next_state       = last_wait ? ST_MEMWB : ST_MEMREAD;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
        ctrl.retire     = 1'b1;
      end
      ST_MEMWRITE: begin
        ctrl.i_or_d       = 1'b1;
        ctrl.write_memory = 1'b1;
        ctrl.retire       = last_wait;
        next_state        = last_wait ? ST_FETCH : ST_MEMWRITE;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
        next_state     = ST_ALUWB;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
        next_state     = ST_ALUWB;
      end
      ST_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.retire     = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = SRCA_REG;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_BRANCH;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
        ctrl.retire        = 1'b1;
      end
      ST_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCS_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.retire     = 1'b1;
      end
      ST_JALR: begin
        // Link reads the PC before this cycle's PC write lands.
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.pc_source  = PCS_JALR;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.retire     = 1'b1;
      end
      ST_LUI: begin
        ctrl.alu_src_a = SRCA_ZERO;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        next_state     = ST_ALUWB;
      end
      default: begin
        ctrl       = '0;
        next_state = ST_FETCH;
      end
    endcase
  end

  // Controls are blanked during reset so no enable fires mid-abort.
  assign oPCWrite     = !reset && ctrl.pc_write;
  assign oPCWriteCond = !reset && ctrl.pc_write_cond;
  assign oIorD        = !reset && ctrl.i_or_d;
  assign oReadMemory  = !reset && ctrl.read_memory;
  assign oWriteMemory = !reset && ctrl.write_memory;
  assign oIRWrite     = !reset && ctrl.ir_write;
  assign oRegWrite    = !reset && ctrl.reg_write;
  assign oMemtoReg    = reset ? 2'd0 : ctrl.mem_to_reg;
  assign oALUSrcA     = reset ? 2'd0 : ctrl.alu_src_a;
  assign oALUSrcB     = reset ? 2'd0 : ctrl.alu_src_b;
  assign oALUOp       = reset ? 2'd0 : ctrl.alu_op;
  assign oPCSource    = reset ? 2'd0 : ctrl.pc_source;
  assign oIllegal     = !reset && ctrl.illegal;
  assign oRetire      = !reset && ctrl.retire;
  assign oState       = state;

endmodule

// File: tb/tb_multiciclo_control.sv
// Bench for multiciclo_control: three instances (MEM_WAIT 0, 2, 3) run random
// instruction streams with occasional mid-instruction resets. A reference
// model expands each opcode into its expected per-cycle control sequence.
module tb_multiciclo_control;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       rd;
    logic       wr;
    logic       irw;
    logic       rw;
    logic [1:0] m2r;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] op;
    logic [1:0] pcs;
    logic       ill;
    logic       ret;
    logic [3:0] st;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);

  logic       clock;
  logic       rst [3];
  logic [6:0] opc [3];
  obs_t       obs [3];

  logic [OBS_W-1:0] exp_q [3][$];
  obs_t             seq_buf [3][$];
  int               rst_edges [3];
  int               n_checks = 0;
  int               n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts edges seen with reset high, so the state check waits one edge.
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++)
      rst_edges[i] = rst[i] ? rst_edges[i] + 1 : 0;
  end

  function automatic int mw_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
  endfunction

  // ---------------- DUT instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pcw, pcwc, iord, rd, wr, irw, rw, ill, ret;
    logic [1:0] m2r, sa, sb, aop, pcs;
    logic [3:0] st;

    multiciclo_control #(.MEM_WAIT(mw_of(g)), .WAIT_W(4)) u_dut (
      .clock        (clock),
      .reset        (rst[g]),
      .iOpcode      (opc[g]),
      .oPCWrite     (pcw),
      .oPCWriteCond (pcwc),
      .oIorD        (iord),
      .oReadMemory  (rd),
      .oWriteMemory (wr),
      .oIRWrite     (irw),
      .oRegWrite    (rw),
      .oMemtoReg    (m2r),
      .oALUSrcA     (sa),
      .oALUSrcB     (sb),
      .oALUOp       (aop),
      .oPCSource    (pcs),
      .oIllegal     (ill),
      .oRetire      (ret),
      .oState       (st)
    );

    assign obs[g] = {pcw, pcwc, iord, rd, wr, irw, rw, m2r, sa, sb, aop, pcs, ill, ret, st};
  end

  // ---------------- reference model ----------------
  // Controls expected in one cycle of a named phase of an instruction.
  function automatic obs_t phase_out(input int st, input bit last, input bit ill);
    obs_t o;
    o = '0;
    o.st = 4'(st);
    case (st)
      0:  begin o.rd = 1; o.sb = 1; o.irw = last; o.pcw = last; end
      1:  begin o.sa = 2; o.sb = 2; o.ill = ill; end
      2:  begin o.sa = 1; o.sb = 2; end
      3:  begin o.iord = 1; o.rd = 1; end
      4:  begin o.rw = 1; o.m2r = 1; o.ret = 1; end
      5:  begin o.iord = 1; o.wr = 1; o.ret = last; end
      6:  begin o.sa = 1; o.sb = 0; o.op = 2; end
      7:  begin o.sa = 1; o.sb = 2; o.op = 2; end
      8:  begin o.rw = 1; o.ret = 1; end
      9:  begin o.sa = 1; o.op = 1; o.pcwc = 1; o.pcs = 1; o.ret = 1; end
      10: begin o.pcw = 1; o.pcs = 1; o.rw = 1; o.m2r = 2; o.ret = 1; end
      11: begin o.sa = 1; o.sb = 2; o.pcs = 2; o.pcw = 1; o.rw = 1; o.m2r = 2; o.ret = 1; end
      12: begin o.sa = 3; o.sb = 2; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Appends `len` cycles of a phase to the instance's sequence buffer.
  task automatic add_phase(input int i, input int st, input int len, input bit ill);
    for (int k = 0; k < len; k++)
      seq_buf[i].push_back(phase_out(st, k == len - 1, ill));
  endtask

  // Expands an opcode into the full per-cycle control sequence, FETCH onward.
  task automatic model(input int i, input logic [6:0] op);
    int mem_len;
    mem_len = mw_of(i) + 1;
    seq_buf[i].delete();
    add_phase(i, 0, mem_len, 0);
    case (op)
      7'b0110011: begin add_phase(i, 1, 1, 0); add_phase(i, 6, 1, 0); add_phase(i, 8, 1, 0); end
      7'b0010011: begin add_phase(i, 1, 1, 0); add_phase(i, 7, 1, 0); add_phase(i, 8, 1, 0); end
      7'b0000011: begin add_phase(i, 1, 1, 0); add_phase(i, 2, 1, 0);
                        add_phase(i, 3, mem_len, 0); add_phase(i, 4, 1, 0); end
      7'b0100011: begin add_phase(i, 1, 1, 0); add_phase(i, 2, 1, 0);
                        add_phase(i, 5, mem_len, 0); end
      7'b1100011: begin add_phase(i, 1, 1, 0); add_phase(i, 9, 1, 0); end
      7'b1101111: begin add_phase(i, 1, 1, 0); add_phase(i, 10, 1, 0); end
      7'b1100111: begin add_phase(i, 1, 1, 0); add_phase(i, 11, 1, 0); end
      7'b0110111: begin add_phase(i, 1, 1, 0); add_phase(i, 12, 1, 0); add_phase(i, 8, 1, 0); end
      7'b0010111: begin add_phase(i, 1, 1, 0); add_phase(i, 8, 1, 0); end
      default:    add_phase(i, 1, 1, 1);
    endcase
  endtask

  // ---------------- driver ----------------
  // Runs one instruction from its first FETCH cycle. abort_at >= 0 asserts
  // reset at that cycle index; -2 picks a random abort point.
  task automatic run_instr(input int i, input logic [6:0] op, input int abort_at);
    int n, len, cut;
    model(i, op);
    len = seq_buf[i].size();
    cut = abort_at;
    if (abort_at == -2) cut = $urandom_range(0, len - 1);
    n = (cut >= 0 && cut < len) ? cut : len;
    opc[i] = op;
    rst[i] = 1'b0;
    for (int k = 0; k < n; k++) exp_q[i].push_back(seq_buf[i][k]);
    repeat (n) begin @(posedge clock); #1; end
    if (n < len) begin
      rst[i] = 1'b1;
      repeat (2) begin @(posedge clock); #1; end
    end
  endtask

  task automatic drive(input int i);
    logic [6:0] legal [10];
    logic [6:0] op;
    legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
    case (i)
      0: begin
        run_instr(i, 7'b0110011, -1);
        run_instr(i, 7'b1100011, -1);
        run_instr(i, 7'b1100111, -1);
        run_instr(i, 7'b1110011, -1);
        run_instr(i, 7'b0100011, -1);
        run_instr(i, 7'b0010111, -1);
        run_instr(i, 7'b0110111, -1);
        run_instr(i, 7'b1101111, -1);
      end
      1: begin
        run_instr(i, 7'b0000011, -1);
        run_instr(i, 7'b0110011, 1);   // reset inside the fetch wait
        run_instr(i, 7'b0000011, -1);
      end
      default: begin
        run_instr(i, 7'b0100011, 7);   // reset on 2nd MEMWRITE cycle
        run_instr(i, 7'b0100011, -1);
        run_instr(i, 7'b0110011, -1);
      end
    endcase
    for (int t = 0; t < 40; t++) begin
      int pick;
      pick = $urandom_range(0, 11);
      op = (pick < 10) ? legal[pick] : 7'($urandom);
      run_instr(i, op, ($urandom_range(0, 7) == 0) ? -2 : -1);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    obs_t o;
    logic [OBS_W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        o = obs[i];
        o.st = 4'd0;
        n_checks++;
        if (o != '0) begin
          n_fail++;
          $display("FAIL reset_ctrl inst=%0d got=%h want=0", i, o);
        end
        if (rst_edges[i] > 0) begin
          n_checks++;
          if (obs[i].st != 4'd0) begin
            n_fail++;
            $display("FAIL reset_state inst=%0d got=%0d want=0", i, obs[i].st);
          end
        end
      end else if (exp_q[i].size() > 0) begin
        e = exp_q[i].pop_front();
        n_checks++;
        if (obs[i] != e) begin
          n_fail++;
          $display("FAIL out inst=%0d t=%0t got=%h want=%h", i, $time, obs[i], e);
        end
      end
    end
  end

  // ---------------- main / report ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      opc[i] = 7'd0;
    end
    repeat (2) @(posedge clock);
    #1;
    fork
      drive(0);
      drive(1);
      drive(2);
    join
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (exp_q[i].size() != 0) begin
        n_fail++;
        $display("FAIL queue_drain inst=%0d got=%0d want=0", i, exp_q[i].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
